// File: rtl/pe_acc.sv
// pe_acc: accumulating processing element with MAC and MAX-pool modes.
// Takes ACC_LEN beats per group, seeded from psum_in on the first beat, and
// presents one saturated result per group over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           abort the open group (beat in the same cycle is dropped)
//   mode            0 = MAC, 1 = MAX; latched on the first beat of a group
//   in_valid/ready  input beat handshake (ifm, wgt, psum_in)
//   out_valid/ready result handshake (psum_out)
//   busy            a group is open (ACCUM or HOLD)
//
// Build option: define PE_ACC_RELU_EN to clamp negative MAC results to 0.

module pe_acc #(
    parameter int IFM_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int FRAC_BITS    = 12,
    parameter int ACC_LEN      = 9,
    parameter int GUARD_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IFM_WIDTH-1:0]    ifm,
    input  logic [WEIGHT_WIDTH-1:0] wgt,
    input  logic [PSUM_WIDTH-1:0]   psum_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PSUM_WIDTH-1:0]   psum_out,
    output logic                    busy
);

    localparam int ACC_WIDTH  = PSUM_WIDTH + GUARD_BITS;
    localparam int PROD_WIDTH = IFM_WIDTH + WEIGHT_WIDTH;
    localparam int CNT_W      = (ACC_LEN > 1) ? $clog2(ACC_LEN + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN);

    // Largest/smallest PSUM_WIDTH values, sign-extended to the accumulator.
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(GUARD_BITS + 1){1'b0}}, {(PSUM_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(GUARD_BITS + 1){1'b1}}, {(PSUM_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mode_q, mode_d;
    logic [PSUM_WIDTH-1:0]   psum_out_q, psum_out_d;

    logic signed [PROD_WIDTH-1:0] prod_full;
    logic signed [PROD_WIDTH-1:0] prod_shr;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  ifm_ext;
    logic signed [ACC_WIDTH-1:0]  psum_ext;
    logic [CNT_W-1:0]             cnt_inc;
    logic [PSUM_WIDTH-1:0]        sat_val;
    logic [PSUM_WIDTH-1:0]        res_val;

    // Full-precision product, floored back to the shared Q point.
    always_comb begin
        prod_full = PROD_WIDTH'($signed(ifm)) * PROD_WIDTH'($signed(wgt));
        prod_shr  = prod_full >>> FRAC_BITS;
        prod_ext  = ACC_WIDTH'(prod_shr);
        ifm_ext   = ACC_WIDTH'($signed(ifm));
        psum_ext  = ACC_WIDTH'($signed(psum_in));
        cnt_inc   = cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        psum_out_d = psum_out_q;
        sat_val    = '0;
        res_val    = '0;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mode_d = mode;
                        if (mode) begin
                            acc_d = (ifm_ext > psum_ext) ? ifm_ext : psum_ext;
                        end else begin
                            acc_d = psum_ext + prod_ext;
                        end
                        if (ACC_LEN == 1) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (mode_q) begin
                            acc_d = (ifm_ext > acc_q) ? ifm_ext : acc_q;
                        end else begin
                            acc_d = acc_q + prod_ext;
                        end
                        if (cnt_inc == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (acc_d > SAT_HI) begin
            sat_val = SAT_HI[PSUM_WIDTH-1:0];
        end else if (acc_d < SAT_LO) begin
            sat_val = SAT_LO[PSUM_WIDTH-1:0];
        end else begin
            sat_val = acc_d[PSUM_WIDTH-1:0];
        end

`ifdef PE_ACC_RELU_EN
        res_val = (!mode_d && sat_val[PSUM_WIDTH-1]) ? '0 : sat_val;
`else
        res_val = sat_val;
`endif

        // Result is captured only on the edge that enters HOLD.
        if (state_d == HOLD && state_q != HOLD) begin
            psum_out_d = res_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            psum_out_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            psum_out_q <= psum_out_d;
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign psum_out  = psum_out_q;

endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: scoreboard bench for pe_acc (default parameters, ACC_LEN = 9).
// Driver pushes expected results; a negedge monitor pops on each handshake.

module tb_pe_acc;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ifm = '0;
    logic [15:0] wgt = '0;
    logic [31:0] psum_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] psum_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pe_acc dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ifm      (ifm),
        .wgt      (wgt),
        .psum_in  (psum_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .psum_out (psum_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the whole group.
    function automatic logic [31:0] model(input bit m, input logic [31:0] seed,
                                          input logic [15:0] f[N],
                                          input logic [15:0] w[N]);
        longint a;
        longint v;
        logic [63:0] r;
        a = longint'($signed(seed));
        for (int i = 0; i < N; i++) begin
            if (m) begin
                v = longint'($signed(f[i]));
                if (v > a) a = v;
            end else begin
                v = longint'($signed(f[i])) * longint'($signed(w[i]));
                a = a + (v >>> 12);
            end
        end
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (a < -64'sd2147483648) a = -64'sd2147483648;
`ifdef PE_ACC_RELU_EN
        if (!m && a < 0) a = 0;
`endif
        r = a;
        return r[31:0];
    endfunction

    // Monitor: every HOLD cycle compares against the head of the scoreboard,
    // which also covers stability under backpressure.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none",
                         psum_out);
            end else begin
                chk("psum_out", psum_out, exp_q[0]);
                chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat();
        int  n;
        bit  rdy;
        n = 0;
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got in_ready 0 expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_group(input int hold);
        int n;
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                tick();
            end
        end
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("release_idle", {30'd0, busy, out_valid}, 32'd0);
    endtask

    task automatic issue(input bit m, input logic [31:0] seed,
                         input logic [15:0] f[N], input logic [15:0] w[N],
                         input int gap, input bit use_lit,
                         input logic [31:0] lit);
        exp_q.push_back(use_lit ? lit : model(m, seed, f, w));
        for (int i = 0; i < N; i++) begin
            ifm     = f[i];
            wgt     = w[i];
            psum_in = (i == 0) ? seed : $urandom;
            mode    = (i == 0) ? m : 1'($urandom);
            beat();
            if (i < N - 1) begin
                ifm  = 16'($urandom);
                mode = 1'($urandom);
                repeat (gap) tick();
            end
        end
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    logic [15:0] fa[N];
    logic [15:0] wa[N];

    initial begin
        int n;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_psum_out", psum_out, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // MAC basic: 9 x (1.0 * 2.0) = 18.0
        for (int i = 0; i < N; i++) begin fa[i] = 16'h1000; wa[i] = 16'h2000; end
        issue(1'b0, 32'h0, fa, wa, 0, 1'b1, 32'h0001_2000);
        finish_group(0);

        // Positive saturation
        for (int i = 0; i < N; i++) begin fa[i] = 16'h1000; wa[i] = 16'h0; end
        wa[0] = 16'h2000;
        issue(1'b0, 32'h7FFF_F000, fa, wa, 0, 1'b1, 32'h7FFF_FFFF);
        finish_group(0);

        // Negative saturation
        wa[0] = 16'hE000;
        issue(1'b0, 32'h8000_1000, fa, wa, 0, 1'b1, 32'h8000_0000);
        finish_group(0);

        // MAX pool with mode toggling after the first beat
        fa = '{16'hFFFB, 16'h0003, 16'h0700, 16'hFFFF, 16'hFF9C,
               16'h0000, 16'h06FF, 16'h8000, 16'h0010};
        for (int i = 0; i < N; i++) wa[i] = 16'($urandom);
        issue(1'b1, 32'hFFFF_FF00, fa, wa, 0, 1'b1, 32'h0000_0700);
        finish_group(0);

        // Stalls of 2 cycles and 5 cycles of backpressure
        for (int i = 0; i < N; i++) begin fa[i] = 16'h1000; wa[i] = 16'h2000; end
        issue(1'b0, 32'h0, fa, wa, 2, 1'b1, 32'h0001_2000);
        finish_group(5);

        // Abort after 4 beats; the beat alongside clear is dropped
        for (int i = 0; i < 4; i++) begin
            ifm = 16'h7000; wgt = 16'h7000; psum_in = 32'h1234_0000;
            mode = 1'b0;
            beat();
        end
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < N; i++) begin fa[i] = 16'h1000; wa[i] = 16'h1000; end
        issue(1'b0, 32'h0, fa, wa, 0, 1'b1, 32'h0000_9000);
        finish_group(0);

        // ReLU: sum of -3.0
        for (int i = 0; i < N; i++) begin fa[i] = 16'h1000; wa[i] = 16'h0; end
        wa[0] = 16'hD000;
`ifdef PE_ACC_RELU_EN
        issue(1'b0, 32'h0, fa, wa, 0, 1'b1, 32'h0000_0000);
`else
        issue(1'b0, 32'h0, fa, wa, 0, 1'b1, 32'hFFFF_D000);
`endif
        finish_group(0);

        // Reset while holding a result
        for (int i = 0; i < N; i++) begin fa[i] = 16'h1000; wa[i] = 16'h2000; end
        out_ready = 1'b0;
        issue(1'b0, 32'h0, fa, wa, 0, 1'b1, 32'h0001_2000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_hold_psum_out", psum_out, 32'd0);
        chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);

        // Randomized groups against the reference model
        for (int g = 0; g < 40; g++) begin
            bit          m;
            logic [31:0] seed;
            m = 1'($urandom);
            case ($urandom_range(0, 3))
                0: seed = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
                1: seed = 32'h8000_0000 + 32'($urandom_range(0, 65535));
                default: seed = $urandom;
            endcase
            for (int i = 0; i < N; i++) begin
                fa[i] = 16'($urandom);
                wa[i] = 16'($urandom);
            end
            issue(m, seed, fa, wa, $urandom_range(0, 2), 1'b0, 32'h0);
            finish_group($urandom_range(0, 3));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
